// File: rtl/aoc_pkg.sv
// Shared types and constants for the group-sum / top-K tracking datapath.
package aoc_pkg;

  typedef enum logic [1:0] {
    S_ACCUM  = 2'd0,
    S_INSERT = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  localparam int DATA_W_DEF = 32;
  localparam int SUM_W_DEF  = 64;
  localparam int K_DEF      = 3;

  // Width that holds the sum of k entries of sum_w bits without truncation.
  function automatic int topk_sum_w(input int sum_w, input int k);
    return sum_w + $clog2(k + 1);
  endfunction

endpackage

// File: rtl/group_topk_tracker_topk_insert.sv
// Combinational sorted insert of one group sum into a descending top-K list.
// TOPK_DEDUP_EN: a sum already present in the list leaves it unchanged.
module topk_insert #(
  parameter int K     = 3,
  parameter int SUM_W = 64
) (
  input  logic [K-1:0][SUM_W-1:0] top,
  input  logic [SUM_W-1:0]        pend,
  output logic [K-1:0][SUM_W-1:0] top_next
);

  logic [K-1:0] gt;
  logic         dup;

  always_comb begin
    dup = 1'b0;
    gt  = '0;
    for (int i = 0; i < K; i++) begin
      // Strict compare: on a tie the existing entry keeps the higher slot.
      gt[i] = pend > top[i];
`ifdef TOPK_DEDUP_EN
      if (top[i] == pend) dup = 1'b1;
`endif
    end

    top_next = top;
    if (!dup) begin
      if (gt[0]) top_next[0] = pend;
      for (int i = 1; i < K; i++) begin
        if (gt[i]) top_next[i] = gt[i-1] ? top[i-1] : pend;
      end
    end
  end

endmodule

// File: rtl/group_topk_tracker.sv
// Streaming group-sum accumulator keeping a descending top-K list of group sums.
// Optional macro TOPK_DEDUP_EN keeps only distinct sums in the list.
module group_topk_tracker
  import aoc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SUM_W  = SUM_W_DEF,
  parameter int K      = K_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clear,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_W-1:0]               in_data,
  input  logic                            in_eof,
  output logic                            out_valid,
  output logic [SUM_W-1:0]                out_max,
  output logic [topk_sum_w(SUM_W, K)-1:0] out_topk_sum,
  output logic [31:0]                     group_count,
  output logic                            overflow,
  output state_e                          dbg_state
);

  localparam int TW = topk_sum_w(SUM_W, K);

  // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
  // in_ready is only high in S_ACCUM without clear, and no beat is taken otherwise.

  state_e                  state, state_next;
  logic [SUM_W-1:0]        acc, pend, grp;
  logic [SUM_W:0]          sum_ext;
  logic                    accept, closes, eof_pend;
  logic [K-1:0][SUM_W-1:0] top, top_ins;

  assign in_ready = (state == S_ACCUM) && !clear;
  assign accept   = in_valid && in_ready;
  assign sum_ext  = {1'b0, acc} + (SUM_W+1)'(in_data);
  // Value of the running group after this beat; a separator leaves it as is.
  assign grp      = (in_data != '0) ? sum_ext[SUM_W-1:0] : acc;
  assign closes   = accept && ((in_data == '0) || in_eof);

  topk_insert #(.K(K), .SUM_W(SUM_W)) u_insert (
    .top      (top),
    .pend     (pend),
    .top_next (top_ins)
  );

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = S_ACCUM;
    end else begin
      case (state)
        S_ACCUM: begin
          if (closes) begin
            if (grp != '0)  state_next = S_INSERT;
            else if (in_eof) state_next = S_DONE;
          end
        end
        S_INSERT: state_next = eof_pend ? S_DONE : S_ACCUM;
        S_DONE:   state_next = S_DONE;
        default:  state_next = S_ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_ACCUM;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      pend        <= '0;
      top         <= '0;
      group_count <= '0;
      overflow    <= 1'b0;
      eof_pend    <= 1'b0;
    end else if (clear) begin
      acc         <= '0;
      pend        <= '0;
      top         <= '0;
      group_count <= '0;
      overflow    <= 1'b0;
      eof_pend    <= 1'b0;
    end else begin
      if (accept) begin
        if (sum_ext[SUM_W]) overflow <= 1'b1;
        if (closes) begin
          acc <= '0;
          if (grp != '0) pend <= grp;
        end else begin
          acc <= grp;
        end
        if (in_eof) eof_pend <= 1'b1;
      end
      if (state == S_INSERT) begin
        top         <= top_ins;
        group_count <= group_count + 32'd1;
      end
    end
  end

  always_comb begin
    out_topk_sum = '0;
    for (int i = 0; i < K; i++) out_topk_sum = out_topk_sum + TW'(top[i]);
  end

  assign out_max   = top[0];
  assign out_valid = (state == S_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_group_topk_tracker.sv
// Bench for group_topk_tracker: directed vector table, corner sequences and
// randomized streams against a queue-and-sort reference model.
module tb_group_topk_tracker;
  import aoc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_eof = 1'b0;
  logic        out_valid;
  logic [63:0] out_max;
  logic [65:0] out_topk_sum;
  logic [31:0] group_count;
  logic        overflow;
  state_e      dbg_state;

  logic        v8 = 1'b0, e8 = 1'b0, rdy8, val8, ovf8;
  logic [7:0]  d8 = '0, max8;
  logic [9:0]  sum8;
  logic [31:0] cnt8;
  state_e      st8;

  int checks = 0;
  int errors = 0;
  logic [79:0] exp_q[$];

  always #5 clk = ~clk;

  group_topk_tracker dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_eof(in_eof), .out_valid(out_valid), .out_max(out_max),
    .out_topk_sum(out_topk_sum), .group_count(group_count), .overflow(overflow),
    .dbg_state(dbg_state)
  );

  group_topk_tracker #(.DATA_W(8), .SUM_W(8), .K(3)) dut8 (
    .clk(clk), .rst(rst), .clear(1'b0), .in_valid(v8), .in_ready(rdy8),
    .in_data(d8), .in_eof(e8), .out_valid(val8), .out_max(max8),
    .out_topk_sum(sum8), .group_count(cnt8), .overflow(ovf8), .dbg_state(st8)
  );

  typedef struct packed {
    int           n;
    logic [15:0][31:0] d;
    logic [63:0]  emax;
    logic [65:0]  esum;
    logic [31:0]  ecnt;
    int           elat;
  } rec_t;

  rec_t vec[4];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic set_rec(input int idx, input logic [31:0] q[$], input logic [63:0] emax,
                         input logic [65:0] esum, input logic [31:0] ecnt, input int elat);
    vec[idx].n = q.size();
    vec[idx].d = '0;
    for (int j = 0; j < q.size(); j++) vec[idx].d[j] = q[j];
    vec[idx].emax = emax;
    vec[idx].esum = esum;
    vec[idx].ecnt = ecnt;
    vec[idx].elat = elat;
  endtask

  // Reference: split into groups, sort all group sums, keep the K largest.
  task automatic model_push(input logic [31:0] beats[$]);
    longint unsigned groups[$];
    longint unsigned uq[$];
    longint unsigned acc = 0;
    longint unsigned tsum = 0;
    int lat = 1;
    for (int j = 0; j < beats.size(); j++) begin
      acc += longint'(beats[j]);
      if (beats[j] == 0 || j == beats.size() - 1) begin
        if (acc != 0) groups.push_back(acc);
        if (j == beats.size() - 1) lat = (acc != 0) ? 2 : 1;
        acc = 0;
      end
    end
    uq = groups;
    uq.rsort();
`ifdef TOPK_DEDUP_EN
    begin
      longint unsigned tmp[$];
      foreach (uq[j]) if (tmp.size() == 0 || tmp[tmp.size()-1] != uq[j]) tmp.push_back(uq[j]);
      uq = tmp;
    end
`endif
    for (int j = 0; j < 3 && j < uq.size(); j++) tsum += uq[j];
    exp_q.push_back(80'(uq.size() > 0 ? uq[0] : 0));
    exp_q.push_back(80'(tsum));
    exp_q.push_back(80'(groups.size()));
    exp_q.push_back(80'(lat));
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic e, input bit gaps, output bit ok);
    ok = 1'b0;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_eof   = e;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_eof   = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
  endtask

  // Sends one stream after a clear and compares against the next exp_q entries.
  task automatic run_stream(input logic [31:0] beats[$], input bit gaps, input string tag);
    int nacc = 0;
    int lat;
    bit ok;
    pulse_clear();
    for (int j = 0; j < beats.size(); j++) begin
      send_beat(beats[j], j == beats.size() - 1, gaps, ok);
      if (ok) nacc++;
    end
    wait_done(lat);
    chk({tag, "_accepted"}, 80'(nacc), 80'(beats.size()));
    chk({tag, "_out_max"}, 80'(out_max), exp_q.pop_front());
    chk({tag, "_topk_sum"}, 80'(out_topk_sum), exp_q.pop_front());
    chk({tag, "_group_count"}, 80'(group_count), exp_q.pop_front());
    chk({tag, "_latency"}, 80'(lat), exp_q.pop_front());
    chk({tag, "_overflow"}, 80'(overflow), 80'(0));
    @(negedge clk);
    chk({tag, "_done_hold"}, 80'({out_valid, in_ready}), 80'(2'b10));
  endtask

  initial begin
    logic [31:0] q[$];
    int lat;
    bit ok;

    q = '{1000, 2000, 3000, 0, 4000, 0, 5000, 6000, 0, 7000, 8000, 9000, 0, 10000};
    set_rec(0, q, 24000, 45000, 5, 2);
`ifdef TOPK_DEDUP_EN
    q = '{5, 0, 5, 0, 5, 0, 1};
    set_rec(1, q, 5, 6, 4, 2);
`else
    q = '{5, 0, 5, 0, 5, 0, 1};
    set_rec(1, q, 5, 15, 4, 2);
`endif
    q = '{0, 0, 7, 0, 0, 0, 3, 0};
    set_rec(2, q, 7, 10, 2, 2);
    q = '{7, 0, 0};
    set_rec(3, q, 7, 7, 1, 1);

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 80'(out_valid), 80'(0));
    chk("rst_in_ready", 80'(in_ready), 80'(1));
    chk("rst_out_max", 80'(out_max), 80'(0));
    chk("rst_topk_sum", 80'(out_topk_sum), 80'(0));
    chk("rst_group_count", 80'(group_count), 80'(0));
    chk("rst_overflow", 80'(overflow), 80'(0));

    // Narrow instance: 200+100 wraps in 8 bits to 44
    @(posedge clk); #1;
    v8 = 1'b1; d8 = 8'd200;
    @(posedge clk); #1 d8 = 8'd100;
    @(posedge clk); #1 begin d8 = 8'd0; e8 = 1'b1; end
    @(posedge clk); #1 begin v8 = 1'b0; e8 = 1'b0; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("w8_overflow", 80'(ovf8), 80'(1));
    chk("w8_out_max", 80'(max8), 80'(44));
    chk("w8_out_valid", 80'(val8), 80'(1));
    chk("w8_group_count", 80'(cnt8), 80'(1));

    // Directed vector table
    for (int i = 0; i < 4; i++) begin
      logic [31:0] bq[$];
      bq = {};
      for (int j = 0; j < vec[i].n; j++) bq.push_back(vec[i].d[j]);
      exp_q.push_back(80'(vec[i].emax));
      exp_q.push_back(80'(vec[i].esum));
      exp_q.push_back(80'(vec[i].ecnt));
      exp_q.push_back(80'(vec[i].elat));
      run_stream(bq, 1'b0, $sformatf("vec%0d", i));
    end

    // First stream again with random idle gaps
    begin
      logic [31:0] bq[$];
      bq = {};
      for (int j = 0; j < vec[0].n; j++) bq.push_back(vec[0].d[j]);
      model_push(bq);
      run_stream(bq, 1'b1, "gaps");
    end

    // Clear in S_DONE with a simultaneous beat: beat must be dropped
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 32'd5; in_eof = 1'b0; clear = 1'b1;
    @(negedge clk);
    chk("clr_in_ready_low", 80'(in_ready), 80'(0));
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("clr_out_valid", 80'(out_valid), 80'(0));
    chk("clr_out_max", 80'(out_max), 80'(0));
    chk("clr_group_count", 80'(group_count), 80'(0));
    chk("clr_in_ready", 80'(in_ready), 80'(1));
    @(posedge clk); #1;
    send_beat(32'd0, 1'b1, 1'b0, ok);
    wait_done(lat);
    chk("clr_empty_latency", 80'(lat), 80'(1));
    chk("clr_beat_dropped", 80'(out_max), 80'(0));
    chk("clr_empty_count", 80'(group_count), 80'(0));

    // Reset in the middle of a group discards the partial sum
    pulse_clear();
    send_beat(32'd1, 1'b0, 1'b0, ok);
    send_beat(32'd2, 1'b0, 1'b0, ok);
    send_beat(32'd3, 1'b0, 1'b0, ok);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_state", 80'(dbg_state), 80'(S_ACCUM));
    @(posedge clk); #1 rst = 1'b0;
    q = '{9, 0};
    model_push(q);
    run_stream(q, 1'b0, "after_rst");

    // Randomized streams
    for (int r = 0; r < 25; r++) begin
      logic [31:0] bq[$];
      int n;
      bq = {};
      n = $urandom_range(4, 24);
      for (int j = 0; j < n; j++)
        bq.push_back(($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 1 << 20)));
      model_push(bq);
      run_stream(bq, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
